can_frame_rx: RTL and testbench
===============================

Name: can_frame_rx

Overview:
- Parametrised CAN 2.0A/2.0B frame receiver and the successor to the sample-strobe frame decoder.
- Runs on the system clock and consumes one bus bit per `sample` strobe from the bit-timing block.
- Performs bit destuffing, CRC-15 checking, form checking and ACK checking.
- Presents decoded frames (11/29-bit ID, RTR, DLC, data) and classified errors to the controller.

Parameters:
- MAX_BYTES, 8: data bytes stored (1..8); bytes beyond this are received and CRC'd but discarded.
- IDLE_BITS, 11: consecutive recessive bits needed after reset or error before an SOF is accepted.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous reset, active-low.
- sample  input  1  one-clk strobe; `can_data_bit` is valid this cycle.
- can_data_bit  input  1  sampled bus level; 0 = dominant.
- frame_valid  output  1  one-clk pulse: error-free frame completed.
- bit_id  output  29  ID; standard frames in [10:0] with [28:11]=0; extended frames as {base[10:0], ext[17:0]}.
- ide  output  1  1 = extended frame.
- rtr  output  1  1 = remote frame.
- nbytes  output  4  raw DLC field.
- can_data  output  8*MAX_BYTES  byte0 in [7:0], MSB-first within each byte.
- err_valid  output  1  one-clk pulse on a detected error.
- err_code  output  4  one-hot {ack, form, crc, stuff}; valid with err_valid, held until the next error.
- tx_ack  output  1  ACK drive request to the transmitter; 0 = drive dominant.
- debug_state  output  4  current FSM state encoding.

Behaviour:
- All logic is on posedge `clk`. FSM, counters and shift registers advance only when `sample`=1.
- Reset values:
  - frame_valid, err_valid, ide, rtr = 0.
  - bit_id, nbytes, can_data, err_code = 0.
  - tx_ack = 1.
  - FSM state = INTEG.
- States:
  - INTEG: count recessive bits; a dominant bit clears the count. At IDLE_BITS go to IDLE.
  - IDLE: a dominant bit is SOF → ID_A. Initialise CRC with SOF, clear the stuff counter.
  - ID_A: 11 bits.
  - RTR_SRR: 1 bit.
  - IDE: 0 → R0; 1 → ID_B.
  - ID_B: 18 bits.
  - RTR_EXT: 1 bit.
  - R1R0: 2 bits for extended frames; R0 is 1 bit for standard frames. Values are ignored.
  - DLC: 4 bits.
  - DATA: 8*min(DLC,8) bits; skipped if rtr=1 or the DLC is 0.
  - CRC: 15 bits.
  - CRC_DEL, ACK, ACK_DEL, EOF (7 bits), then IDLE.
  - ERR: any error goes here, clears partial outputs' shadow registers (published outputs untouched), then → INTEG.
- Destuffing:
  - Active from SOF through the last CRC bit.
  - After 5 equal consecutive bits the next bit is a stuff bit. It is dropped: it does not enter the CRC or a field, and it restarts the run count at 1 with its own value.
  - A stuff bit equal to the previous bit → stuff error.
  - The stuff rule does not apply at CRC_DEL and later.
- CRC:
  - Polynomial 0x4599 with init 0, over destuffed bits SOF..end of DATA.
  - At the end of the CRC field, the received CRC must equal the computed CRC, else crc error (flagged at CRC_DEL).
- Form errors:
  - Dominant CRC_DEL, dominant ACK_DEL, or dominant in any EOF bit.
  - Exception: a dominant bit at EOF bit 7 is ignored and the frame is accepted (overload condition, not an error).
- ACK: a recessive ACK slot → ack error.
- Error reporting: the error is reported on the sample where it is detected. If several errors are detected on one sample, the priority is stuff > form > crc > ack, and only the highest is set.
- Publishing:
  - Decoded fields go to shadow registers and are copied to the outputs in the same cycle that frame_valid pulses.
  - frame_valid pulses on the clk of the sample of the last EOF bit.
  - Outputs stay stable between frame_valid pulses.
- DLC rules:
  - A DLC of 9..15 reads 8 bytes; nbytes reports the raw value.
  - Data bytes with index >= MAX_BYTES are shifted into the CRC only.
- Async reset mid-frame: immediate return to INTEG; no pulse is generated.

Optional Feature:
- Macro: CAN_RX_ACK_DRIVE_EN.
- When defined: tx_ack=0 for exactly the ACK bit period. It goes low at the CRC_DEL sample when the CRC matched and no error is pending, and returns high at the ACK sample.
- When undefined: tx_ack is tied to 1. The ack slot is still checked.

Test Plan:
- Standard data frame, ID 0x123, DLC 2, data 0xAA,0x55, correct stuffing/CRC, dominant ACK → frame_valid=1, bit_id=0x123, ide=0, rtr=0, nbytes=2, can_data[15:0]=0x55AA, err_valid=0.
- Extended remote frame, ID 0x1ABCDE12, DLC 4 → frame_valid, bit_id=0x1ABCDE12, ide=1, rtr=1, no data bits consumed.
- Six consecutive dominant bits inside ID_A → err_valid, err_code=4'b0001, FSM back in INTEG; the next SOF is accepted only after 11 recessive bits.
- Valid frame with one CRC bit inverted → err_code=4'b0010; with CAN_RX_ACK_DRIVE_EN, tx_ack stays 1.
- Recessive ACK slot → err_code=4'b1000. Dominant EOF bit 3 → err_code=4'b0100. Dominant EOF bit 7 → frame_valid.
- MAX_BYTES=4, DLC 8, data 0x01..0x08 → frame_valid, can_data=0x04030201, nbytes=8. Separately, rst_n asserted mid-DATA → all outputs reset, no pulses.

Source files
------------

// File: rtl/can_frame_rx.sv
// CAN 2.0A/2.0B frame receiver: destuffing, CRC-15, form and ACK checking.
// Define CAN_RX_ACK_DRIVE_EN to drive the ACK slot through tx_ack.
module can_frame_rx #(
  parameter int MAX_BYTES = 8,
  parameter int IDLE_BITS = 11
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sample,
  input  logic                   can_data_bit,
  output logic                   frame_valid,
  output logic [28:0]            bit_id,
  output logic                   ide,
  output logic                   rtr,
  output logic [3:0]             nbytes,
  output logic [8*MAX_BYTES-1:0] can_data,
  output logic                   err_valid,
  output logic [3:0]             err_code,
  output logic                   tx_ack,
  output logic [3:0]             debug_state
);

  typedef enum logic [3:0] {
    S_INTEG, S_IDLE, S_ID_A, S_RTR_SRR, S_IDE, S_ID_B, S_RTR_EXT, S_R1R0,
    S_DLC, S_DATA, S_CRC, S_CRC_DEL, S_ACK, S_ACK_DEL, S_EOF, S_ERR
  } state_t;

  localparam int          IW       = $clog2(IDLE_BITS + 1);
  localparam logic [14:0] CRC_POLY = 15'h4599;
  localparam logic [3:0]  E_STUFF  = 4'b0001;
  localparam logic [3:0]  E_CRC    = 4'b0010;
  localparam logic [3:0]  E_FORM   = 4'b0100;
  localparam logic [3:0]  E_ACK    = 4'b1000;

  state_t                 state;
  logic [IW-1:0]          integ_cnt;
  logic [6:0]             bit_cnt;
  logic [2:0]             run_cnt;
  logic                   last_bit;
  logic [14:0]            crc;
  logic [14:0]            crc_rx;
  logic                   crc_ok;
  logic [28:0]            id_sh;
  logic                   ide_sh;
  logic                   rtr_sh;
  logic [3:0]             dlc_sh;
  logic [8*MAX_BYTES-1:0] data_sh;

  logic        stuff_zone, crc_zone, is_stuff, stuff_err;
  logic [14:0] crc_next;
  logic [3:0]  dlc_next, dlc_eff;
  logic [6:0]  data_last;
  logic [3:0]  err_now;

  assign stuff_zone = (state >= S_ID_A) && (state <= S_CRC);
  assign crc_zone   = (state >= S_ID_A) && (state <= S_DATA);
  assign is_stuff   = stuff_zone && (run_cnt == 3'd5);
  assign stuff_err  = is_stuff && (can_data_bit == last_bit);
  assign crc_next   = {crc[13:0], 1'b0} ^ ((can_data_bit ^ crc[14]) ? CRC_POLY : 15'h0);
  assign dlc_next   = {dlc_sh[2:0], can_data_bit};
  assign dlc_eff    = (dlc_sh > 4'd8) ? 4'd8 : dlc_sh;
  assign data_last  = {dlc_eff, 3'b000} - 7'd1;
  assign debug_state = state;

  // Only the highest-priority error is reported when several coincide.
  always_comb begin
    // NOTE: default first so no path leaves err_now unassigned (no latch).
    err_now = '0;
    if (sample) begin
      if (stuff_err) begin
        err_now = E_STUFF;
      end else begin
        case (state)
          S_CRC_DEL: if (!can_data_bit) err_now = E_FORM;
                     else if (!crc_ok)  err_now = E_CRC;
          S_ACK:     if (can_data_bit)  err_now = E_ACK;
          S_ACK_DEL: if (!can_data_bit) err_now = E_FORM;
          S_EOF:     if (!can_data_bit && bit_cnt != 7'd6) err_now = E_FORM;
          default:   err_now = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: shadow registers are plain flops, so they get a reset like everything else.
      state       <= S_INTEG;
      integ_cnt   <= '0;
      bit_cnt     <= '0;
      run_cnt     <= '0;
      last_bit    <= 1'b1;
      crc         <= '0;
      crc_rx      <= '0;
      crc_ok      <= 1'b0;
      id_sh       <= '0;
      ide_sh      <= 1'b0;
      rtr_sh      <= 1'b0;
      dlc_sh      <= '0;
      data_sh     <= '0;
      frame_valid <= 1'b0;
      bit_id      <= '0;
      ide         <= 1'b0;
      rtr         <= 1'b0;
      nbytes      <= '0;
      can_data    <= '0;
      err_valid   <= 1'b0;
      err_code    <= '0;
    end else begin
      // NOTE: non-blocking throughout; later assignments in this block override defaults.
      frame_valid <= 1'b0;
      err_valid   <= 1'b0;
      if (sample) begin
        if (err_now != '0) begin
          err_valid <= 1'b1;
          err_code  <= err_now;
          state     <= S_ERR;
          bit_cnt   <= '0;
        end else if (is_stuff) begin
          run_cnt  <= 3'd1;
          last_bit <= can_data_bit;
        end else begin
          if (stuff_zone) begin
            run_cnt  <= (can_data_bit == last_bit) ? run_cnt + 3'd1 : 3'd1;
            last_bit <= can_data_bit;
          end
          if (crc_zone) crc <= crc_next;
          bit_cnt <= bit_cnt + 7'd1;
          case (state)
            S_INTEG: begin
              if (!can_data_bit) begin
                integ_cnt <= '0;
              end else if (integ_cnt == IW'(IDLE_BITS - 1)) begin
                integ_cnt <= '0;
                state     <= S_IDLE;
              end else begin
                integ_cnt <= integ_cnt + 1'b1;
              end
            end
            S_IDLE: if (!can_data_bit) begin
              // A dominant SOF fed into a zero CRC leaves it zero.
              state    <= S_ID_A;
              bit_cnt  <= '0;
              run_cnt  <= 3'd1;
              last_bit <= 1'b0;
              crc      <= '0;
              id_sh    <= '0;
              ide_sh   <= 1'b0;
              rtr_sh   <= 1'b0;
              dlc_sh   <= '0;
              data_sh  <= '0;
            end
            S_ID_A: begin
              id_sh <= {id_sh[27:0], can_data_bit};
              if (bit_cnt == 7'd10) begin state <= S_RTR_SRR; bit_cnt <= '0; end
            end
            S_RTR_SRR: begin rtr_sh <= can_data_bit; state <= S_IDE; end
            S_IDE: begin
              ide_sh  <= can_data_bit;
              bit_cnt <= '0;
              state   <= can_data_bit ? S_ID_B : S_R1R0;
            end
            S_ID_B: begin
              id_sh <= {id_sh[27:0], can_data_bit};
              if (bit_cnt == 7'd17) begin state <= S_RTR_EXT; bit_cnt <= '0; end
            end
            S_RTR_EXT: begin rtr_sh <= can_data_bit; bit_cnt <= '0; state <= S_R1R0; end
            S_R1R0: if (!ide_sh || bit_cnt == 7'd1) begin state <= S_DLC; bit_cnt <= '0; end
            S_DLC: begin
              dlc_sh <= dlc_next;
              if (bit_cnt == 7'd3) begin
                bit_cnt <= '0;
                state   <= (rtr_sh || dlc_next == 4'd0) ? S_CRC : S_DATA;
              end
            end
            S_DATA: begin
              // Bytes past MAX_BYTES only feed the CRC.
              for (int b = 0; b < MAX_BYTES; b++)
                if (bit_cnt[6:3] == b[3:0]) data_sh[8*b +: 8] <= {data_sh[8*b +: 7], can_data_bit};
              if (bit_cnt == data_last) begin state <= S_CRC; bit_cnt <= '0; end
            end
            S_CRC: begin
              crc_rx <= {crc_rx[13:0], can_data_bit};
              if (bit_cnt == 7'd14) begin
                crc_ok  <= ({crc_rx[13:0], can_data_bit} == crc);
                state   <= S_CRC_DEL;
                bit_cnt <= '0;
              end
            end
            S_CRC_DEL: state <= S_ACK;
            S_ACK:     state <= S_ACK_DEL;
            S_ACK_DEL: begin state <= S_EOF; bit_cnt <= '0; end
            S_EOF: if (bit_cnt == 7'd6) begin
              frame_valid <= 1'b1;
              bit_id      <= id_sh;
              ide         <= ide_sh;
              rtr         <= rtr_sh;
              nbytes      <= dlc_sh;
              can_data    <= data_sh;
              state       <= S_IDLE;
            end
            S_ERR: begin
              id_sh     <= '0;
              ide_sh    <= 1'b0;
              rtr_sh    <= 1'b0;
              dlc_sh    <= '0;
              data_sh   <= '0;
              integ_cnt <= IW'(can_data_bit);
              state     <= S_INTEG;
            end
            default: state <= S_INTEG;
          endcase
        end
      end
    end
  end

`ifdef CAN_RX_ACK_DRIVE_EN
  // Drive dominant for exactly the ACK bit after a clean CRC delimiter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      tx_ack <= 1'b1;
    else if (sample) tx_ack <= !(state == S_CRC_DEL && err_now == '0);
  end
`else
  assign tx_ack = 1'b1;
`endif

endmodule

// File: tb/tb_can_frame_rx.sv
// Directed bench for can_frame_rx: builds stuffed CAN frames with a CRC-15
// encoder and checks decoded fields, error codes and pulse counts.
module tb_can_frame_rx;

  localparam logic [3:0] ST_INTEG = 4'd0;
  localparam logic [3:0] ST_IDLE  = 4'd1;
  localparam logic [3:0] ST_ERR   = 4'd15;
`ifdef CAN_RX_ACK_DRIVE_EN
  localparam bit ACK_DRV = 1'b1;
`else
  localparam bit ACK_DRV = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample = 1'b0;
  logic        can_data_bit = 1'b1;
  logic        frame_valid, ide, rtr, err_valid, tx_ack;
  logic [28:0] bit_id;
  logic [3:0]  nbytes, err_code, debug_state;
  logic [63:0] can_data;
  logic        frame_valid_4, ide_4, rtr_4, err_valid_4, tx_ack_4;
  logic [28:0] bit_id_4;
  logic [3:0]  nbytes_4, err_code_4, debug_state_4;
  logic [31:0] can_data_4;

  can_frame_rx dut (
    .clk(clk), .rst_n(rst_n), .sample(sample), .can_data_bit(can_data_bit),
    .frame_valid(frame_valid), .bit_id(bit_id), .ide(ide), .rtr(rtr), .nbytes(nbytes),
    .can_data(can_data), .err_valid(err_valid), .err_code(err_code), .tx_ack(tx_ack),
    .debug_state(debug_state)
  );

  can_frame_rx #(.MAX_BYTES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .sample(sample), .can_data_bit(can_data_bit),
    .frame_valid(frame_valid_4), .bit_id(bit_id_4), .ide(ide_4), .rtr(rtr_4), .nbytes(nbytes_4),
    .can_data(can_data_4), .err_valid(err_valid_4), .err_code(err_code_4), .tx_ack(tx_ack_4),
    .debug_state(debug_state_4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails = 0;
  int fv_cnt = 0, ev_cnt = 0, fv4_cnt = 0, ev4_cnt = 0;
  bit q[$];

  always @(negedge clk) begin
    if (frame_valid)   fv_cnt++;
    if (err_valid)     ev_cnt++;
    if (frame_valid_4) fv4_cnt++;
    if (err_valid_4)   ev4_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input bit b);
    @(negedge clk);
    can_data_bit = b;
    sample = 1'b1;
    @(negedge clk);
    sample = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) send_bit(1'b1);
  endtask

  // Raw fields, CRC-15 (poly 0x4599), stuffing SOF..CRC, then trailer into q.
  task automatic build_frame(input logic [28:0] id, input bit ext, input bit rr,
                             input logic [3:0] dlc, input logic [63:0] data,
                             input int flip_crc, input bit ack_rec, input int eof_dom);
    bit raw[$];
    logic [14:0] crc;
    int nb, run;
    bit last;
    raw = {};
    raw.push_back(1'b0);
    if (!ext) begin
      for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
      raw.push_back(rr); raw.push_back(1'b0); raw.push_back(1'b0);
    end else begin
      for (int i = 28; i >= 18; i--) raw.push_back(id[i]);
      raw.push_back(1'b1); raw.push_back(1'b1);
      for (int i = 17; i >= 0; i--) raw.push_back(id[i]);
      raw.push_back(rr); raw.push_back(1'b0); raw.push_back(1'b0);
    end
    for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
    nb = rr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
    for (int k = 0; k < nb; k++)
      for (int i = 7; i >= 0; i--) raw.push_back(data[8*k+i]);
    crc = '0;
    foreach (raw[j]) crc = {crc[13:0], 1'b0} ^ ((raw[j] ^ crc[14]) ? 15'h4599 : 15'h0);
    if (flip_crc >= 0) crc[flip_crc] = ~crc[flip_crc];
    for (int i = 14; i >= 0; i--) raw.push_back(crc[i]);
    q = {};
    run = 0;
    last = 1'b1;
    foreach (raw[j]) begin
      q.push_back(raw[j]);
      if (raw[j] == last) run++;
      else begin run = 1; last = raw[j]; end
      if (run == 5 && j != raw.size() - 1) begin
        q.push_back(~last);
        last = ~last;
        run = 1;
      end
    end
    q.push_back(1'b1);
    q.push_back(ack_rec);
    q.push_back(1'b1);
    for (int e = 1; e <= 7; e++) q.push_back(e == eof_dom ? 1'b0 : 1'b1);
  endtask

  task automatic send_frame(input string name, input logic [28:0] id, input bit ext, input bit rr,
                            input logic [3:0] dlc, input logic [63:0] data,
                            input int flip_crc, input bit ack_rec, input int eof_dom);
    int del_idx;
    build_frame(id, ext, rr, dlc, data, flip_crc, ack_rec, eof_dom);
    del_idx = q.size() - 10;
    foreach (q[i]) begin
      send_bit(q[i]);
      if (i == del_idx)
        check({name, " tx_ack in ack slot"}, 64'(tx_ack), (ACK_DRV && flip_crc < 0) ? 64'd0 : 64'd1);
      if (i == del_idx + 1)
        check({name, " tx_ack after ack"}, 64'(tx_ack), 64'd1);
    end
  endtask

  int fv0, ev0, fv40;

  initial begin
    // Reset state
    #23;
    check("rst frame_valid", 64'(frame_valid), 64'd0);
    check("rst err_valid", 64'(err_valid), 64'd0);
    check("rst bit_id", 64'(bit_id), 64'd0);
    check("rst ide/rtr", {62'd0, ide, rtr}, 64'd0);
    check("rst nbytes", 64'(nbytes), 64'd0);
    check("rst can_data", can_data, 64'd0);
    check("rst err_code", 64'(err_code), 64'd0);
    check("rst tx_ack", 64'(tx_ack), 64'd1);
    check("rst state", 64'(debug_state), 64'(ST_INTEG));
    @(negedge clk);
    rst_n = 1'b1;

    // Integration boundary: 10 recessive bits are not enough, 11 are
    idle(10);
    check("integ 10 bits", 64'(debug_state), 64'(ST_INTEG));
    idle(1);
    check("integ 11 bits", 64'(debug_state), 64'(ST_IDLE));

    // Standard data frame
    fv0 = fv_cnt; ev0 = ev_cnt;
    send_frame("std", 29'h123, 1'b0, 1'b0, 4'd2, 64'h55AA, -1, 1'b0, 0);
    check("std frame_valid", 64'(fv_cnt - fv0), 64'd1);
    check("std err_valid", 64'(ev_cnt - ev0), 64'd0);
    check("std bit_id", 64'(bit_id), 64'h123);
    check("std ide/rtr", {62'd0, ide, rtr}, 64'd0);
    check("std nbytes", 64'(nbytes), 64'd2);
    check("std can_data", can_data, 64'h55AA);
    idle(2);

    // Extended remote frame
    fv0 = fv_cnt; ev0 = ev_cnt;
    send_frame("ext rtr", 29'h1ABCDE12, 1'b1, 1'b1, 4'd4, 64'd0, -1, 1'b0, 0);
    check("ext frame_valid", 64'(fv_cnt - fv0), 64'd1);
    check("ext err_valid", 64'(ev_cnt - ev0), 64'd0);
    check("ext bit_id", 64'(bit_id), 64'h1ABCDE12);
    check("ext ide/rtr", {62'd0, ide, rtr}, 64'd3);
    check("ext nbytes", 64'(nbytes), 64'd4);
    check("ext can_data", can_data, 64'd0);
    idle(2);

    // Six dominant bits from SOF: stuff error
    ev0 = ev_cnt;
    repeat (6) send_bit(1'b0);
    check("stuff err_valid", 64'(ev_cnt - ev0), 64'd1);
    check("stuff err_code", 64'(err_code), 64'h1);
    check("stuff state", 64'(debug_state), 64'(ST_ERR));
    check("stuff keeps bit_id", 64'(bit_id), 64'h1ABCDE12);
    idle(1);
    check("stuff back in integ", 64'(debug_state), 64'(ST_INTEG));
    idle(9);
    check("post-err 10 bits", 64'(debug_state), 64'(ST_INTEG));
    idle(1);
    check("post-err 11 bits", 64'(debug_state), 64'(ST_IDLE));

    // CRC error
    fv0 = fv_cnt; ev0 = ev_cnt;
    send_frame("crc", 29'h123, 1'b0, 1'b0, 4'd2, 64'h55AA, 3, 1'b0, 0);
    check("crc err_valid", 64'(ev_cnt - ev0), 64'd1);
    check("crc err_code", 64'(err_code), 64'h2);
    check("crc no frame", 64'(fv_cnt - fv0), 64'd0);
    idle(12);

    // Recessive ACK slot
    fv0 = fv_cnt; ev0 = ev_cnt;
    send_frame("ack", 29'h321, 1'b0, 1'b0, 4'd1, 64'h3C, -1, 1'b1, 0);
    check("ack err_valid", 64'(ev_cnt - ev0), 64'd1);
    check("ack err_code", 64'(err_code), 64'h8);
    check("ack no frame", 64'(fv_cnt - fv0), 64'd0);
    idle(12);

    // Dominant EOF bit 3: form error
    fv0 = fv_cnt; ev0 = ev_cnt;
    send_frame("eof3", 29'h321, 1'b0, 1'b0, 4'd1, 64'h3C, -1, 1'b0, 3);
    check("eof3 err_valid", 64'(ev_cnt - ev0), 64'd1);
    check("eof3 err_code", 64'(err_code), 64'h4);
    check("eof3 no frame", 64'(fv_cnt - fv0), 64'd0);
    idle(12);

    // Dominant EOF bit 7: overload, frame accepted
    fv0 = fv_cnt; ev0 = ev_cnt;
    send_frame("eof7", 29'h321, 1'b0, 1'b0, 4'd1, 64'h3C, -1, 1'b0, 7);
    check("eof7 frame_valid", 64'(fv_cnt - fv0), 64'd1);
    check("eof7 err_valid", 64'(ev_cnt - ev0), 64'd0);
    check("eof7 bit_id", 64'(bit_id), 64'h321);
    check("eof7 can_data", can_data, 64'h3C);
    check("eof7 err_code held", 64'(err_code), 64'h4);
    idle(2);

    // 8 data bytes into both widths
    fv0 = fv_cnt; fv40 = fv4_cnt;
    send_frame("dlc8", 29'h7F0, 1'b0, 1'b0, 4'd8, 64'h0807060504030201, -1, 1'b0, 0);
    check("dlc8 frame_valid", 64'(fv_cnt - fv0), 64'd1);
    check("dlc8 frame_valid mb4", 64'(fv4_cnt - fv40), 64'd1);
    check("dlc8 bit_id", 64'(bit_id), 64'h7F0);
    check("dlc8 can_data", can_data, 64'h0807060504030201);
    check("dlc8 can_data mb4", 64'(can_data_4), 64'h04030201);
    check("dlc8 nbytes mb4", 64'(nbytes_4), 64'd8);
    idle(2);

    // DLC above 8 reads 8 bytes, reports raw value
    fv0 = fv_cnt;
    send_frame("dlc12", 29'h0A5, 1'b0, 1'b0, 4'd12, 64'h1122334455667788, -1, 1'b0, 0);
    check("dlc12 frame_valid", 64'(fv_cnt - fv0), 64'd1);
    check("dlc12 nbytes", 64'(nbytes), 64'd12);
    check("dlc12 can_data", can_data, 64'h1122334455667788);
    check("dlc12 can_data mb4", 64'(can_data_4), 64'h55667788);
    idle(2);

    // Async reset in the middle of the data field
    fv0 = fv_cnt; ev0 = ev_cnt; fv40 = fv4_cnt;
    build_frame(29'h7F0, 1'b0, 1'b0, 4'd8, 64'h0807060504030201, -1, 1'b0, 0);
    for (int i = 0; i < 35; i++) send_bit(q[i]);
    rst_n = 1'b0;
    #1;
    check("mid rst state", 64'(debug_state), 64'(ST_INTEG));
    check("mid rst bit_id", 64'(bit_id), 64'd0);
    check("mid rst nbytes", 64'(nbytes), 64'd0);
    check("mid rst can_data", can_data, 64'd0);
    check("mid rst can_data mb4", 64'(can_data_4), 64'd0);
    check("mid rst err_code", 64'(err_code), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 35; i < q.size(); i++) send_bit(q[i]);
    idle(3);
    check("mid rst no frame", 64'(fv_cnt - fv0), 64'd0);
    check("mid rst no frame mb4", 64'(fv4_cnt - fv40), 64'd0);
    check("mid rst no error", 64'(ev_cnt - ev0), 64'd0);
    check("mid rst can_data held", can_data, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
